// File: rtl/bcd_serial_adder_pkg.sv
// Shared BCD constants and the serial adder FSM encoding.
package bcd_serial_adder_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;
  localparam int BCD_ADJ = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_serial_adder_digit.sv
// Combinational single-digit BCD adder; shared by the BCD arithmetic blocks.
module bcd_digit_adder
  import bcd_serial_adder_pkg::*;
(
  input  logic [BCD_W-1:0] a_d,
  input  logic [BCD_W-1:0] b_d,
  input  logic             c,
  output logic [BCD_W-1:0] digit,
  output logic             carry,
  output logic             invalid
);

  logic [BCD_W:0]   s;
  logic [BCD_W+1:0] s_adj;

  always_comb begin
    s       = {1'b0, a_d} + {1'b0, b_d} + {{BCD_W{1'b0}}, c};
    // Out-of-range digits still go through the normal +6 correction.
    s_adj   = {1'b0, s} + (BCD_W+2)'(BCD_ADJ);
    carry   = (s > (BCD_W+1)'(BCD_MAX));
    digit   = carry ? s_adj[BCD_W-1:0] : s[BCD_W-1:0];
    invalid = (a_d > BCD_W'(BCD_MAX)) | (b_d > BCD_W'(BCD_MAX));
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one digit per clock, LSD first, through one digit adder.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                    cout,
  output logic                    err
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic [BCD_W-1:0] dig;
  logic             dig_carry;
  logic             dig_inv;

  // Operands shift right each ADD cycle, so the current digit is always at the bottom.
  bcd_digit_adder u_digit (
    .a_d     (opa_q[BCD_W-1:0]),
    .b_d     (opb_q[BCD_W-1:0]),
    .c       (carry_q),
    .digit   (dig),
    .carry   (dig_carry),
    .invalid (dig_inv)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        sum_d[idx_q*BCD_W +: BCD_W] = dig;
        carry_d = dig_carry;
        err_d   = err_q | dig_inv;
        opa_d   = opa_q >> BCD_W;
        opb_d   = opb_q >> BCD_W;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = dig_carry;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == ST_ADD);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder with DIGITS=4: directed BCD vectors.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got sum=%h cout=%b err=%b at cycle %0d, expected no done",
                 sum, cout, err, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (sum !== e.sum || cout !== e.cout || err !== e.err || cyc != e.cyc) begin
          errors++;
          $display("FAIL result: got sum=%h cout=%b err=%b cycle=%0d expected sum=%h cout=%b err=%b cycle=%0d",
                   sum, cout, err, cyc, e.sum, e.cout, e.err, e.cyc);
        end
      end
    end
  end

  // Call at a negedge; leaves the bench at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic [W-1:0] esum, input logic ecout, input logic eerr,
                        input bit hold);
    exp_t e;
    a = ta; b = tb; cin = tc; start = 1'b1;
    e.sum = esum; e.cout = ecout; e.err = eerr; e.cyc = cyc + 1 + DIGITS;
    q.push_back(e);
    for (int j = 0; j <= DIGITS; j++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk("busy", 32'(busy), 32'(j < DIGITS));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    run_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    run_op(16'h0000, 16'hF000, 1'b0, 16'h5000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // start while busy is ignored
    begin
      exp_t e;
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      e.sum = 16'h3333; e.cout = 1'b0; e.err = 1'b0; e.cyc = cyc + 1 + DIGITS;
      q.push_back(e);
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; a = 16'h9999;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
    end

    // reset mid-operation: outputs clear at once, no done for the abandoned op
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum",  32'(sum),  32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_err",  32'(err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // back-to-back with start held high: done at cycles 5, 10, 15 of the burst
    run_op(16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    run_op(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h0123, 16'h0877, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("burst_end_busy", 32'(busy), 32'd0);

    for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
